// File: rtl/mouse_pkg.sv
// rtl/mouse_pkg.sv - shared constants, state encodings and baud derivation for the mouse link
package mouse_pkg;

    // Fixed header bits occupying byte0[7:3]
    localparam logic [4:0] MOUSE_HDR = 5'b10100;

    // Bytes per packet: header/buttons, delta_x, delta_y
    localparam int PKT_BYTES = 3;

    // Serializer states for one 8N1 byte
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Packet sequencer states
    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_SEND = 1'b1
    } seq_state_t;

    // Clock cycles per line bit (integer division)
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/mouse_tx_if.sv
// rtl/mouse_tx_if.sv - packet handshake bundle between a packet source and mouse_tx
interface mouse_tx_if;

    logic       pkt_valid;
    logic       btn_left;
    logic       btn_right;
    logic       btn_middle;
    logic [7:0] delta_x;
    logic [7:0] delta_y;
    logic       pkt_ready;
    logic       busy;
    logic       pkt_done;

    // Packet source side
    modport master (
        output pkt_valid, btn_left, btn_right, btn_middle, delta_x, delta_y,
        input  pkt_ready, busy, pkt_done
    );

    // Transmitter side
    modport slave (
        input  pkt_valid, btn_left, btn_right, btn_middle, delta_x, delta_y,
        output pkt_ready, busy, pkt_done
    );

endinterface

// File: rtl/mouse_tx_uart_tx_byte.sv
// rtl/mouse_tx_uart_tx_byte.sv - baud counter and 8N1 serializer for a single byte
module uart_tx_byte
    import mouse_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int                CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_data;
    logic             r_tx;

    logic w_bit_end;
    logic w_load;

    assign w_bit_end = (r_cnt == CNT_MAX);
    // done marks the final cycle of the stop bit so the next byte can chain with no gap
    assign done      = (r_state == ST_STOP) && w_bit_end;
    assign w_load    = start && ((r_state == ST_IDLE) || done);
    assign tx        = r_tx;

    // Serializer FSM: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_data    <= 8'h00;
            r_tx      <= 1'b1;
        end else if (w_load) begin
            r_state   <= ST_START;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_data    <= data;
            r_tx      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_tx  <= 1'b1;
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_data[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_data[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mouse_tx.sv
// rtl/mouse_tx.sv - mouse packet UART transmitter: handshake, capture buffer and byte sequencer
module mouse_tx
    import mouse_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 19200
) (
    input  logic      clk,
    input  logic      rst_n,
    mouse_tx_if.slave pkt,
    output logic      tx_pin
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);

    seq_state_t  r_state;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_buf;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;

    logic       w_accept;
    logic       w_byte_done;
    logic       w_last_byte;
    logic       w_chain;
    logic       w_start;
    logic [7:0] w_byte0;
    logic [7:0] w_data;

    assign w_byte0     = {MOUSE_HDR, pkt.btn_middle, pkt.btn_right, pkt.btn_left};
    assign w_accept    = r_ready && pkt.pkt_valid;
    assign w_last_byte = (r_byte_idx == 2'(PKT_BYTES - 1));
    assign w_chain     = (r_state == SEQ_SEND) && w_byte_done && !w_last_byte;
    assign w_start     = w_accept || w_chain;
    // byte0 goes straight from the inputs so the start bit begins on the accepting edge
    assign w_data      = w_accept ? w_byte0 : r_buf[15:8];

    assign pkt.pkt_ready = r_ready;
    assign pkt.busy      = r_busy;
    assign pkt.pkt_done  = r_done;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .data  (w_data),
        .tx    (tx_pin),
        .done  (w_byte_done)
    );

    // Packet sequencer: capture on handshake, chain three bytes, pulse pkt_done on return to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SEQ_IDLE;
            r_byte_idx <= 2'd0;
            r_buf      <= 24'h0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                SEQ_IDLE: begin
                    if (w_accept) begin
                        r_buf      <= {pkt.delta_y, pkt.delta_x, w_byte0};
                        r_byte_idx <= 2'd0;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SEQ_SEND;
                    end
                end
                SEQ_SEND: begin
                    if (r_byte_idx == 2'd3) begin
                        r_byte_idx <= 2'd0;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= SEQ_IDLE;
                    end else if (w_byte_done) begin
                        if (w_last_byte) begin
                            r_byte_idx <= 2'd0;
                            r_ready    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= SEQ_IDLE;
                        end else begin
                            // rotate so the following byte sits in [15:8]
                            r_buf      <= {r_buf[7:0], r_buf[23:8]};
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule
